hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard-detection and forwarding-control block for the 5-stage pipeline, the successor to the fixed EX/MEM-compare hazard unit. It tracks every in-flight register write in a DEPTH-entry shift-register scoreboard (EX onward), raises a same-cycle stall for the instruction in ID, and produces registered forwarding selects aligned to that instruction's EX cycle. It sits beside stage2 and drives the IF/ID hold, the PC enable and the EX operand muxes.

## Interface
- REG_AW, 4: register address width; 2**REG_AW architectural registers.
- DEPTH, 3: number of tracked stages after ID. Slot 0 = EX, slot DEPTH-1 = the stage writing the register file. Minimum 2.
- LOAD_LAT, 1: stall cycles needed by a consumer directly behind a load; 0 ≤ LOAD_LAT ≤ DEPTH-1.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a valid instruction.
- id_src1  in  REG_AW  Rn address.
- id_src1_used  in  1  instruction reads Rn.
- id_src2  in  REG_AW  second source address (Rm or Rd for stores).
- id_two_src  in  1  instruction reads the second source.
- id_wb_en  in  1  instruction writes a register.
- id_dest  in  REG_AW  destination address.
- id_mem_r_en  in  1  instruction is a load.
- flush  in  1  branch taken in EX; kill the ID instruction.
- hazard  out  1  combinational stall request for ID/IF.
- fwd_sel1, fwd_sel2  out  $clog2(DEPTH+1)  registered EX-operand selects: 0 = register-file value, k = value from slot k (1 = MEM, 2 = WB for DEPTH=3).
- busy_vec  out  2**REG_AW  registered bitmap of registers with a pending write.

## Operation
- Slot contents: {valid, dest, is_load}. Every cycle, slot k <= slot k-1 for k ≥ 1; slots always advance and are never stalled.
- Slot 0 insert: {1, id_dest, id_mem_r_en} when id_valid & id_wb_en & !hazard & !flush; otherwise a bubble (valid=0).
- A source "matches" slot k when the slot is valid, dest equals the source, and the source is used (id_src1_used / id_two_src).
- The register file is write-through, so slot DEPTH-1 never causes a hazard and never needs forwarding.
- With forwarding (see Configuration): hazard = id_valid & match of any used source against a valid load in slots 0..LOAD_LAT-1.
- Forward select per source: youngest (lowest k) matching slot k in 0..DEPTH-2 gives select k+1, because the producer advances one slot before the consumer reaches EX. No match gives 0.
- Flush has priority over hazard. A flushed instruction is never inserted, and its fwd_sel registers load 0. The hazard output itself is still computed normally.
- fwd_sel registers load the computed selects when the ID instruction is accepted (id_valid & !hazard & !flush); otherwise they load 0.
- busy_vec bit r = OR over valid slots 0..DEPTH-2 whose dest equals r. It is recomputed from the next-state slots and registered.
- Reset: all slots invalid; hazard = 0, fwd_sel1 = fwd_sel2 = 0, busy_vec = 0 in the cycle after rst is sampled. Reset mid-operation discards all in-flight entries.

## Timing
- hazard: zero latency, combinational from ID inputs and slot state.
- fwd_sel: one-cycle latency. It is valid exactly in the cycle the accepted instruction occupies EX.
- A load-use dependency stalls exactly LOAD_LAT cycles. A non-load dependency stalls 0 cycles with forwarding, and up to DEPTH-1 cycles without it.
- busy_vec is valid one cycle after insert. It clears the cycle after the producer leaves slot DEPTH-2.

## Configuration
- FORWARD_EN defined: behaviour as described in Operation.
- FORWARD_EN undefined: fwd_sel1 and fwd_sel2 are tied to 0. hazard = id_valid & a used source matching any valid slot 0..DEPTH-2, regardless of is_load. LOAD_LAT is ignored.

## Test plan
- Reset: assert rst for 2 cycles with id_valid=1 → hazard=0, fwd_sel=0, busy_vec=0 the cycle after release.
- ALU dependency, FORWARD_EN, DEPTH=3: ADD R1 then SUB R2,R1,R3 → hazard=0; fwd_sel1=1 during SUB's EX. With one instruction between them → fwd_sel1=2. With two between → fwd_sel1=0.
- Load-use, LOAD_LAT=1: LDR R4 then ADD R5,R4,R4 with two_src=1 → hazard=1 for exactly 1 cycle, one bubble inserted; then fwd_sel1=fwd_sel2=2 in ADD's EX.
- FORWARD_EN undefined: ADD R1 then SUB using R1 → hazard=1 for 2 cycles, then 0; fwd_sel stays 0.
- Flush with hazard: a load in slot 0, the dependent instruction in ID, and flush=1 → nothing inserted into slot 0, fwd_sel=0 next cycle, busy_vec never shows the consumer's dest.
- Unused source: MOV R6,#1 with src1_used=0 and id_src1=R4 while a load to R4 is in slot 0 → hazard=0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : DEPTH-slot in-flight write scoreboard producing the ID stall
//               request, EX-aligned forwarding selects and a pending-write map.
//               Optional forwarding controlled by macro FORWARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int REG_AW   = 4,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         id_valid,
    input  logic [REG_AW-1:0]            id_src1,
    input  logic                         id_src1_used,
    input  logic [REG_AW-1:0]            id_src2,
    input  logic                         id_two_src,
    input  logic                         id_wb_en,
    input  logic [REG_AW-1:0]            id_dest,
    input  logic                         id_mem_r_en,
    input  logic                         flush,
    output logic                         hazard,
    output logic [$clog2(DEPTH+1)-1:0]   fwd_sel1,
    output logic [$clog2(DEPTH+1)-1:0]   fwd_sel2,
    output logic [(2**REG_AW)-1:0]       busy_vec
);

    localparam int c_selW    = $clog2(DEPTH + 1);
    localparam int c_numRegs = 2 ** REG_AW;

    logic [DEPTH-1:0]             r_slotValid;
    logic [DEPTH-1:0]             r_slotLoad;
    logic [DEPTH-1:0][REG_AW-1:0] r_slotDest;

    logic [DEPTH-1:0]             w_nextValid;
    logic [DEPTH-1:0]             w_nextLoad;
    logic [DEPTH-1:0][REG_AW-1:0] w_nextDest;

    // Only slots 0..DEPTH-2 can matter: the register file is write-through.
    logic [DEPTH-2:0]             w_match1;
    logic [DEPTH-2:0]             w_match2;

    logic                         w_hazardHit;
    logic [c_selW-1:0]            w_sel1;
    logic [c_selW-1:0]            w_sel2;
    logic                         w_accept;
    logic                         w_insert;
    logic [c_numRegs-1:0]         w_busyNext;

    logic [c_numRegs-1:0]         r_busy;
    logic [c_selW-1:0]            r_sel1;
    logic [c_selW-1:0]            r_sel2;

    generate
        for (genvar k = 0; k < DEPTH - 1; k++) begin : g_match
            assign w_match1[k] = r_slotValid[k] & id_src1_used & (r_slotDest[k] == id_src1);
            assign w_match2[k] = r_slotValid[k] & id_two_src   & (r_slotDest[k] == id_src2);
        end
    endgenerate

`ifdef FORWARD_EN
    // Only a load still inside its latency window forces a stall.
    always_comb begin
        w_hazardHit = 1'b0;
        for (int k = 0; k < DEPTH - 1; k++) begin
            if ((k < LOAD_LAT) && r_slotLoad[k] && (w_match1[k] || w_match2[k])) begin
                w_hazardHit = 1'b1;
            end
        end
    end

    // Scan oldest to youngest so the youngest producer wins; the producer
    // moves one slot further before the consumer reaches EX, hence k+1.
    always_comb begin
        w_sel1 = '0;
        w_sel2 = '0;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            if (w_match1[k]) begin
                w_sel1 = c_selW'(k + 1);
            end
            if (w_match2[k]) begin
                w_sel2 = c_selW'(k + 1);
            end
        end
    end
`else
    localparam int c_unusedLoadLat = LOAD_LAT;

    always_comb begin
        w_hazardHit = |{w_match1, w_match2};
    end

    always_comb begin
        w_sel1 = '0;
        w_sel2 = '0;
    end
`endif

    assign hazard   = id_valid & w_hazardHit;
    assign w_accept = id_valid & ~hazard & ~flush;
    assign w_insert = w_accept & id_wb_en;

    assign w_nextValid = {r_slotValid[DEPTH-2:0], w_insert};
    assign w_nextLoad  = {r_slotLoad[DEPTH-2:0], (w_insert & id_mem_r_en)};
    assign w_nextDest  = {r_slotDest[DEPTH-2:0], id_dest};

    always_comb begin
        w_busyNext = '0;
        for (int k = 0; k < DEPTH - 1; k++) begin
            if (w_nextValid[k]) begin
                w_busyNext[w_nextDest[k]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slotValid <= '0;
            r_slotLoad  <= '0;
            r_slotDest  <= '0;
            r_busy      <= '0;
            r_sel1      <= '0;
            r_sel2      <= '0;
        end else begin
            r_slotValid <= w_nextValid;
            r_slotLoad  <= w_nextLoad;
            r_slotDest  <= w_nextDest;
            r_busy      <= w_busyNext;
            r_sel1      <= w_accept ? w_sel1 : '0;
            r_sel2      <= w_accept ? w_sel2 : '0;
        end
    end

    // The WB slot is kept to model the full pipe but never feeds a decision.
    logic w_unusedBits;
    assign w_unusedBits = ^{r_slotLoad, r_slotValid[DEPTH-1], r_slotDest[DEPTH-1]};

    assign fwd_sel1 = r_sel1;
    assign fwd_sel2 = r_sel2;
    assign busy_vec = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// Table-driven bench for hazard_scoreboard (DEPTH=3, LOAD_LAT=1); expectations
// follow the FORWARD_EN setting of the build.
module tb_hazard_scoreboard;

    localparam int REG_AW   = 4;
    localparam int DEPTH    = 3;
    localparam int LOAD_LAT = 1;
`ifdef FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_src1;
    logic        id_src1_used;
    logic [3:0]  id_src2;
    logic        id_two_src;
    logic        id_wb_en;
    logic [3:0]  id_dest;
    logic        id_mem_r_en;
    logic        flush;
    logic        hazard;
    logic [1:0]  fwd_sel1;
    logic [1:0]  fwd_sel2;
    logic [15:0] busy_vec;

    hazard_scoreboard #(.REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src1_used(id_src1_used),
        .id_src2(id_src2), .id_two_src(id_two_src),
        .id_wb_en(id_wb_en), .id_dest(id_dest), .id_mem_r_en(id_mem_r_en),
        .flush(flush), .hazard(hazard),
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        v;
        logic [3:0]  s1;
        logic        u1;
        logic [3:0]  s2;
        logic        u2;
        logic        wb;
        logic [3:0]  d;
        logic        ld;
        logic        fl;
        logic        eh;
        logic [1:0]  e1;
        logic [1:0]  e2;
        logic [15:0] eb;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic put(input logic r, v, input logic [3:0] s1, input logic u1,
                       input logic [3:0] s2, input logic u2, wb, input logic [3:0] d,
                       input logic ld, fl, eh, input logic [1:0] e1, e2, input logic [15:0] eb);
        vec_t t;
        t.r = r; t.v = v; t.s1 = s1; t.u1 = u1; t.s2 = s2; t.u2 = u2; t.wb = wb;
        t.d = d; t.ld = ld; t.fl = fl; t.eh = eh; t.e1 = e1; t.e2 = e2; t.eb = eb;
        vecs.push_back(t);
    endtask

    // Instruction shorthands: two-source ALU op, load R<d>,[R9], idle cycle, non-writing op
    task automatic alu(input logic r, input logic [3:0] d, s1, s2, input logic fl, eh,
                       input logic [1:0] e1, e2, input logic [15:0] eb);
        put(r, 1, s1, 1, s2, 1, 1, d, 0, fl, eh, e1, e2, eb);
    endtask
    task automatic ldr(input logic [3:0] d, input logic [15:0] eb);
        put(0, 1, 4'd9, 1, 4'd0, 0, 1, d, 1, 0, 0, 2'd0, 2'd0, eb);
    endtask
    task automatic nop(input logic [1:0] e1, e2, input logic [15:0] eb);
        put(0, 0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, e1, e2, eb);
    endtask
    task automatic mid(input logic [15:0] eb);
        put(0, 1, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 2'd0, 2'd0, eb);
    endtask

    task automatic drive(input vec_t t);
        rst = t.r; id_valid = t.v; id_src1 = t.s1; id_src1_used = t.u1;
        id_src2 = t.s2; id_two_src = t.u2; id_wb_en = t.wb; id_dest = t.d;
        id_mem_r_en = t.ld; flush = t.fl;
    endtask

    task automatic check(input string nm, input int idx, input logic [31:0] got, exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got 0x%0h expected 0x%0h", nm, idx, got, exp);
        end
    endtask

    task automatic fillTable();
        nop(0, 0, 16'h0000);
        if (FWD) begin
            // ALU dependency, distance 1
            alu(0, 1, 2, 3, 0, 0, 0, 0, 16'h0000);
            alu(0, 2, 1, 3, 0, 0, 0, 0, 16'h0002);
            nop(1, 0, 16'h0006);
            nop(0, 0, 16'h0004);
            nop(0, 0, 16'h0000);
            // distance 2
            alu(0, 1, 2, 3, 0, 0, 0, 0, 16'h0000);
            mid(16'h0002);
            alu(0, 2, 1, 3, 0, 0, 0, 0, 16'h0002);
            nop(2, 0, 16'h0004);
            nop(0, 0, 16'h0004);
            nop(0, 0, 16'h0000);
            // distance 3: producer already in the write-through stage
            alu(0, 1, 2, 3, 0, 0, 0, 0, 16'h0000);
            mid(16'h0002);
            mid(16'h0002);
            alu(0, 2, 1, 3, 0, 0, 0, 0, 16'h0000);
            nop(0, 0, 16'h0004);
            nop(0, 0, 16'h0004);
            nop(0, 0, 16'h0000);
            // load-use: one stall, then both operands from slot 2
            ldr(4, 16'h0000);
            alu(0, 5, 4, 4, 0, 1, 0, 0, 16'h0010);
            alu(0, 5, 4, 4, 0, 0, 0, 0, 16'h0010);
            nop(2, 2, 16'h0020);
            nop(0, 0, 16'h0020);
            nop(0, 0, 16'h0000);
        end else begin
            alu(0, 1, 2, 3, 0, 0, 0, 0, 16'h0000);
            alu(0, 2, 1, 3, 0, 1, 0, 0, 16'h0002);
            alu(0, 2, 1, 3, 0, 1, 0, 0, 16'h0002);
            alu(0, 2, 1, 3, 0, 0, 0, 0, 16'h0000);
            nop(0, 0, 16'h0004);
            nop(0, 0, 16'h0004);
            nop(0, 0, 16'h0000);
            ldr(4, 16'h0000);
            alu(0, 5, 4, 4, 0, 1, 0, 0, 16'h0010);
            alu(0, 5, 4, 4, 0, 1, 0, 0, 16'h0010);
            alu(0, 5, 4, 4, 0, 0, 0, 0, 16'h0000);
            nop(0, 0, 16'h0020);
            nop(0, 0, 16'h0020);
            nop(0, 0, 16'h0000);
        end
        // unused source naming a pending load destination
        ldr(4, 16'h0000);
        put(0, 1, 4'd4, 0, 4'd4, 0, 1, 4'd6, 0, 0, 0, 2'd0, 2'd0, 16'h0010);
        nop(0, 0, 16'h0050);
        nop(0, 0, 16'h0040);
        nop(0, 0, 16'h0000);
        // flush of a stalled consumer
        ldr(4, 16'h0000);
        alu(0, 5, 4, 4, 1, 1, 0, 0, 16'h0010);
        nop(0, 0, 16'h0010);
        nop(0, 0, 16'h0000);
        // flush of a consumer that would forward (hazard only without forwarding)
        alu(0, 1, 2, 3, 0, 0, 0, 0, 16'h0000);
        alu(0, 2, 1, 3, 1, !FWD, 0, 0, 16'h0002);
        nop(0, 0, 16'h0002);
        nop(0, 0, 16'h0000);
        // reset mid-operation discards the in-flight write
        alu(0, 1, 2, 3, 0, 0, 0, 0, 16'h0000);
        alu(1, 2, 1, 3, 0, !FWD, 0, 0, 16'h0002);
        nop(0, 0, 16'h0000);
        nop(0, 0, 16'h0000);
    endtask

    initial begin
        int cnt;
        fillTable();

        // two reset cycles with a valid instruction sitting in ID
        rst = 1; id_valid = 1; id_src1 = 4'd1; id_src1_used = 1; id_src2 = 4'd1;
        id_two_src = 1; id_wb_en = 1; id_dest = 4'd1; id_mem_r_en = 1; flush = 0;
        @(negedge clk); #2;
        check("rst_hazard", 0, 32'(hazard), 32'd0);
        check("rst_sel1", 0, 32'(fwd_sel1), 32'd0);
        check("rst_busy", 0, 32'(busy_vec), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #2;
            check("hazard", i, 32'(hazard), 32'(vecs[i].eh));
            check("fwd_sel1", i, 32'(fwd_sel1), 32'(vecs[i].e1));
            check("fwd_sel2", i, 32'(fwd_sel2), 32'(vecs[i].e2));
            check("busy_vec", i, 32'(busy_vec), 32'(vecs[i].eb));
        end

        // stall length for a load-use pair, measured rather than tabulated
        @(negedge clk);
        rst = 0; id_valid = 1; id_src1 = 4'd9; id_src1_used = 1; id_src2 = 4'd0;
        id_two_src = 0; id_wb_en = 1; id_dest = 4'd7; id_mem_r_en = 1; flush = 0;
        #2;
        check("ldr_hazard", 0, 32'(hazard), 32'd0);
        @(negedge clk);
        id_src1 = 4'd7; id_src2 = 4'd7; id_two_src = 1; id_dest = 4'd8; id_mem_r_en = 0;
        #2;
        cnt = 0;
        while (hazard === 1'b1 && cnt < 10) begin
            cnt++;
            @(negedge clk); #2;
        end
        check("stall_cycles", 0, 32'(cnt), FWD ? 32'(LOAD_LAT) : 32'(DEPTH - 1));
        @(negedge clk);
        id_valid = 0;
        #2;
        check("stall_sel1", 0, 32'(fwd_sel1), FWD ? 32'(LOAD_LAT + 1) : 32'd0);
        check("stall_sel2", 0, 32'(fwd_sel2), FWD ? 32'(LOAD_LAT + 1) : 32'd0);
        check("stall_busy", 0, 32'(busy_vec), 32'h0100);
        repeat (3) @(negedge clk);
        #2;
        check("drain_busy", 0, 32'(busy_vec), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
